apu_issue_ctrl: RTL

Core-side initiator for the APU request/response interface that the vector accelerator serves. It takes one accelerator instruction per handshake from the core pipeline, drives `apu_req_o`, `apu_op_o`, `apu_operands_o` and `apu_flags_o` until the request is granted, and tracks in-flight requests in an in-order tag FIFO. It also matches each returned `apu_rvalid_i` to its destination register and issues a registered writeback to the core register file.

---
 rtl/accelerator_pkg.sv | 14 +
 rtl/apu_tag_fifo.sv | 47 ++++
 rtl/apu_issue_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/accelerator_pkg.sv
// accelerator_pkg: shared types and widths for the core-side APU interface.
package accelerator_pkg;
    localparam int APU_OP_W        = 6;
    localparam int APU_FLAGS_IN_W  = 15;
    localparam int APU_FLAGS_OUT_W = 5;
    localparam int APU_RD_W        = 5;

    typedef enum logic {IDLE, REQ} apu_issue_state_t;

    typedef struct packed {
        logic [APU_RD_W-1:0] rd;
        logic                wb;
    } apu_tag_t;
endpackage

// File: rtl/apu_tag_fifo.sv
// apu_tag_fifo: in-order tag FIFO with simultaneous push/pop, including push while full with a pop.
module apu_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 6,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_pop, do_push;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/apu_issue_ctrl.sv
// apu_issue_ctrl: issues core accelerator instructions on the APU request bus and
// matches in-order responses to destination registers for a registered writeback.
module apu_issue_ctrl
    import accelerator_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [APU_OP_W-1:0]        issue_op_i,
    input  logic [95:0]                issue_operands_i,
    input  logic [APU_FLAGS_IN_W-1:0]  issue_flags_i,
    input  logic [RD_W-1:0]            issue_rd_i,
    input  logic                       issue_wb_i,
    output logic                       apu_req_o,
    input  logic                       apu_gnt_i,
    output logic [APU_OP_W-1:0]        apu_op_o,
    output logic [95:0]                apu_operands_o,
    output logic [APU_FLAGS_IN_W-1:0]  apu_flags_o,
    input  logic                       apu_rvalid_i,
    input  logic [31:0]                apu_result_i,
    input  logic [APU_FLAGS_OUT_W-1:0] apu_fflags_i,
    output logic                       wb_valid_o,
    output logic [RD_W-1:0]            wb_rd_o,
    output logic [31:0]                wb_data_o,
    output logic [APU_FLAGS_OUT_W-1:0] wb_fflags_o,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int CW = $clog2(DEPTH + 1);

    apu_issue_state_t state, next_state;
    logic             accept, full, empty, pop, do_wb;
    logic [RD_W:0]    pop_tag;
    logic [CW-1:0]    count;

    // Ready deliberately ignores apu_rvalid_i so the response path stays off it.
    assign issue_ready_o = (state == IDLE || apu_gnt_i) && !full;
    assign accept        = issue_valid_i && issue_ready_o;
    assign pop           = apu_rvalid_i && !empty;
    assign do_wb         = pop && pop_tag[0] && pop_tag[RD_W:1] != '0;
    assign apu_req_o     = state == REQ;
    assign busy_o        = count != '0;

    always_comb begin
        next_state = accept ? REQ : (state == REQ && apu_gnt_i) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            apu_op_o       <= '0;
            apu_operands_o <= '0;
            apu_flags_o    <= '0;
            wb_valid_o     <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            wb_fflags_o    <= '0;
            err_o          <= 1'b0;
        end else begin
            state      <= next_state;
            wb_valid_o <= do_wb;
            if (accept) begin
                apu_op_o       <= issue_op_i;
                apu_operands_o <= issue_operands_i;
                apu_flags_o    <= issue_flags_i;
            end
            if (do_wb) begin
                wb_rd_o     <= pop_tag[RD_W:1];
                wb_data_o   <= apu_result_i;
                wb_fflags_o <= apu_fflags_i;
            end
            if (apu_rvalid_i && empty) err_o <= 1'b1;
        end
    end

    apu_tag_fifo #(.DEPTH(DEPTH), .W(RD_W + 1)) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   ({issue_rd_i, issue_wb_i}),
        .pop   (apu_rvalid_i),
        .dout  (pop_tag),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule
